// File: rtl/mac_quant_core_if.sv
// mac_quant_core_if: command, operand stream and result bundle for mac_quant_core.
interface mac_quant_core_if #(
    parameter int DWIDTH = 8,
    parameter int LWIDTH = 8
);
    logic              start_i;
    logic [LWIDTH-1:0] length_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DWIDTH-1:0] a_i;
    logic [DWIDTH-1:0] b_i;
    logic              busy_o;
    logic              calc_done_o;
    logic [DWIDTH-1:0] calc_result_o;

    modport master (
        output start_i, length_i, in_valid_i, a_i, b_i,
        input  in_ready_o, busy_o, calc_done_o, calc_result_o
    );

    modport slave (
        input  start_i, length_i, in_valid_i, a_i, b_i,
        output in_ready_o, busy_o, calc_done_o, calc_result_o
    );
endinterface

// File: rtl/mac_quant_core.sv
// mac_quant_core: unsigned multiply-accumulate, shift/saturate to a byte, guarded done pulse.
// MAC_ROUND_EN selects round-half-up quantisation instead of truncation.
module mac_quant_core #(
    parameter int DWIDTH    = 8,
    parameter int LWIDTH    = 8,
    parameter int ACC_WIDTH = 24,
    parameter int SHIFT     = 8,
    parameter int DONE_GAP  = 4
) (
    input logic            clk,
    input logic            reset_n,
    mac_quant_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, QUANT, GAP} state_t;
    localparam int GW = $clog2(DONE_GAP + 1);
    localparam logic [ACC_WIDTH:0] MAXQ = (ACC_WIDTH + 1)'({DWIDTH{1'b1}});
`ifdef MAC_ROUND_EN
    localparam logic [ACC_WIDTH:0] RND = (ACC_WIDTH + 1)'(1) << (SHIFT - 1);
`else
    localparam logic [ACC_WIDTH:0] RND = '0;
`endif
    state_t              r_state;
    logic [LWIDTH-1:0]   r_len;
    logic [LWIDTH-1:0]   r_cnt;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [GW-1:0]       r_gap;
    logic                r_ready;
    logic                r_busy;
    logic                r_done;
    logic [DWIDTH-1:0]   r_result;
    logic [2*DWIDTH-1:0] w_prod;
    logic [ACC_WIDTH:0]  w_sum;
    logic [ACC_WIDTH:0]  w_q;
    logic                w_beat;
    logic                w_last;

    assign w_prod = bus.a_i * bus.b_i;
    // One spare bit catches overflow so the accumulator can pin at all-ones
    assign w_sum  = {1'b0, r_acc} + (ACC_WIDTH + 1)'(w_prod);
    assign w_q    = ({1'b0, r_acc} + RND) >> SHIFT;
    assign w_beat = r_state == RUN && bus.in_valid_i;
    assign w_last = r_cnt == r_len - LWIDTH'(1);

    assign bus.in_ready_o    = r_ready;
    assign bus.busy_o        = r_busy;
    assign bus.calc_done_o   = r_done;
    assign bus.calc_result_o = r_result;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_gap    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start_i) begin
                    r_len   <= bus.length_i;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                    r_ready <= bus.length_i != '0;
                    r_state <= bus.length_i == '0 ? QUANT : RUN;
                end
                RUN: if (w_beat) begin
                    r_acc <= w_sum[ACC_WIDTH] ? '1 : w_sum[ACC_WIDTH-1:0];
                    r_cnt <= r_cnt + LWIDTH'(1);
                    if (w_last) begin
                        r_ready <= 1'b0;
                        r_state <= QUANT;
                    end
                end
                QUANT: begin
                    r_result <= w_q > MAXQ ? '1 : w_q[DWIDTH-1:0];
                    r_done   <= 1'b1;
                    r_gap    <= '0;
                    r_state  <= GAP;
                end
                GAP: if (r_gap == GW'(DONE_GAP - 1)) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_gap <= r_gap + GW'(1);
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_quant_core.sv
// tb_mac_quant_core: randomized and directed checks of mac_quant_core against a sum/clamp/shift model.
module tb_mac_quant_core;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_vec = 0;
    int n_err = 0;
    int op_a[$];
    int op_b[$];
`ifdef MAC_ROUND_EN
    localparam longint RND = 128;
`else
    localparam longint RND = 0;
`endif

    always #5 clk = ~clk;

    mac_quant_core_if #(.DWIDTH(8), .LWIDTH(8)) bus ();
    mac_quant_core dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int model(input int len);
        longint s = 0;
        for (int i = 0; i < len; i++) s += longint'(op_a[i]) * longint'(op_b[i]);
        if (s > 64'd16777215) s = 16777215;
        s = (s + RND) >> 8;
        return s > 255 ? 255 : int'(s);
    endfunction

    task automatic set_ops(input int len, input bit all_max);
        op_a = {};
        op_b = {};
        for (int i = 0; i < len; i++) begin
            op_a.push_back(all_max ? 255 : int'($urandom_range(0, 255)));
            op_b.push_back(all_max ? 255 : int'($urandom_range(0, 255)));
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (bus.busy_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("idle_wait", 32'(bus.busy_o), 0);
    endtask

    // gapmode: 0 = valid every cycle, 1 = random valid, 2 = two idle cycles before each beat
    task automatic run_cmd(input int len, input int gapmode);
        int beats = 0;
        int t = 0;
        int exp = model(len);
        wait_idle();
        bus.start_i    = 1'b1;
        bus.length_i   = 8'(len);
        bus.in_valid_i = 1'b1;
        bus.a_i        = 8'($urandom);
        bus.b_i        = 8'($urandom);
        @(negedge clk);
        bus.start_i = 1'b0;
        check("start_busy", 32'(bus.busy_o), 1);
        check("start_ready", 32'(bus.in_ready_o), 32'(len != 0));
        while (beats < len && t < 4 * len + 20) begin
            bus.in_valid_i = gapmode == 0 ? 1'b1 : gapmode == 1 ? 1'($urandom_range(0, 1)) : 1'(t % 3 == 2);
            bus.a_i = bus.in_valid_i ? 8'(op_a[beats]) : 8'($urandom);
            bus.b_i = bus.in_valid_i ? 8'(op_b[beats]) : 8'($urandom);
            if (bus.in_valid_i && bus.in_ready_o) beats++;
            @(negedge clk);
            t++;
        end
        check("beats", 32'(beats), 32'(len));
        bus.in_valid_i = 1'b0;
        check("quant_done", 32'(bus.calc_done_o), 0);
        check("quant_ready", 32'(bus.in_ready_o), 0);
        @(negedge clk);
        check("done", 32'(bus.calc_done_o), 1);
        check("result", 32'(bus.calc_result_o), 32'(exp));
        @(negedge clk);
        check("done_fall", 32'(bus.calc_done_o), 0);
        check("result_hold", 32'(bus.calc_result_o), 32'(exp));
    endtask

    initial begin
        int last = 0;
        int n = 0;
        bus.start_i    = 1'b0;
        bus.length_i   = '0;
        bus.in_valid_i = 1'b0;
        bus.a_i        = '0;
        bus.b_i        = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.in_ready_o), 0);
        check("rst_busy", 32'(bus.busy_o), 0);
        check("rst_done", 32'(bus.calc_done_o), 0);
        check("rst_result", 32'(bus.calc_result_o), 0);
        reset_n = 1'b1;

        op_a = '{10, 20, 30};
        op_b = '{10, 10, 10};
        run_cmd(3, 0);
        op_a = '{20};
        op_b = '{20};
        run_cmd(1, 0);
        set_ops(255, 1'b1);
        run_cmd(255, 0);
        set_ops(4, 1'b0);
        run_cmd(4, 2);
        run_cmd(0, 0);
        for (int i = 0; i < 6; i++) begin
            int len = int'($urandom_range(1, 20));
            set_ops(len, 1'b0);
            run_cmd(len, 1);
        end

        // start held high: dones must be spaced by run + quant + guard
        wait_idle();
        bus.start_i    = 1'b1;
        bus.length_i   = 8'd1;
        bus.in_valid_i = 1'b1;
        bus.a_i        = 8'd16;
        bus.b_i        = 8'd16;
        for (int c = 0; c < 80 && n < 3; c++) begin
            @(negedge clk);
            if (bus.calc_done_o) begin
                if (n > 0) check("held_spacing", 32'(c - last), 7);
                check("held_result", 32'(bus.calc_result_o), 1);
                last = c;
                n++;
            end
        end
        check("held_dones", 32'(n), 3);
        bus.start_i    = 1'b0;
        bus.in_valid_i = 1'b0;

        wait_idle();
        bus.start_i  = 1'b1;
        bus.length_i = 8'd10;
        @(negedge clk);
        bus.start_i    = 1'b0;
        bus.in_valid_i = 1'b1;
        bus.a_i        = 8'd200;
        bus.b_i        = 8'd200;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.in_ready_o), 0);
        check("mid_rst_busy", 32'(bus.busy_o), 0);
        check("mid_rst_done", 32'(bus.calc_done_o), 0);
        check("mid_rst_result", 32'(bus.calc_result_o), 0);
        reset_n = 1'b1;
        bus.in_valid_i = 1'b0;
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.calc_done_o) n++;
        end
        check("mid_rst_no_done", 32'(n), 0);
        set_ops(5, 1'b0);
        run_cmd(5, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
